// File: rtl/vdp_vram_sprite_server.sv
// VRAM read server for the VDP sprite engine: arbitrates SAT byte-pair fetches,
// 4-byte pattern-row fetches and CPU writes onto a dual-port VRAM and registers
// the returned bytes onto the shared sprite data bus.
module vdp_vram_sprite_server #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_L,
    input  logic                   satGo,
    input  logic [1:0][ADDR_W-1:0] satAddr,
    input  logic                   patGo,
    input  logic [7:0]             sprPat,
    input  logic [2:0]             patRow,
    input  logic                   sprPatBase,
    input  logic                   cpuWrReq,
    input  logic [ADDR_W-1:0]      cpuAddr,
    input  logic [DATA_W-1:0]      cpuData,
    output logic                   cpuWrAck,
    output logic [ADDR_W-1:0]      memAddrA,
    output logic [ADDR_W-1:0]      memAddrB,
    output logic                   memWeA,
    output logic [DATA_W-1:0]      memWdataA,
    input  logic [DATA_W-1:0]      memRdataA,
    input  logic [DATA_W-1:0]      memRdataB,
    output logic [5:0][DATA_W-1:0] sprData,
    output logic                   satValid,
    output logic                   patValid,
    output logic                   collision
);

    typedef enum logic [0:0] {IDLE, PAT_B1} state_t;

    state_t                   state_q, state_d;
    logic                     sat_pend_q, sat_pend_d;
    logic [1:0][ADDR_W-1:0]   sat_pend_addr_q, sat_pend_addr_d;
    logic                     pat_pend_q, pat_pend_d;
    logic [ADDR_W-1:0]        pat_pend_addr_q, pat_pend_addr_d;
    logic [ADDR_W-1:0]        pat_addr_q, pat_addr_d;
    logic                     sat_rd_q, sat_rd_d;
    logic                     pat_b0_q, pat_b0_d;
    logic                     pat_b1_q, pat_b1_d;
    logic                     collision_d;
    logic                     sat_go_taken, pat_go_taken;
    logic [ADDR_W-1:0]        pat_go_addr;

    // Pattern rows are 4-byte aligned, so the byte offset lives in the low two bits.
    function automatic logic [ADDR_W-1:0] row_byte(input logic [ADDR_W-1:0] base,
                                                   input logic [1:0] off);
        return {base[ADDR_W-1:2], off};
    endfunction

    assign pat_go_addr = ADDR_W'({sprPatBase, sprPat, patRow, 2'b00});

    // Per-cycle port arbitration, FSM next state and deferral of go pulses that lose.
    always_comb begin
        state_d         = state_q;
        sat_pend_d      = sat_pend_q;
        sat_pend_addr_d = sat_pend_addr_q;
        pat_pend_d      = pat_pend_q;
        pat_pend_addr_d = pat_pend_addr_q;
        pat_addr_d      = pat_addr_q;
        collision_d     = collision_q_int();
        sat_rd_d        = 1'b0;
        pat_b0_d        = 1'b0;
        pat_b1_d        = 1'b0;
        sat_go_taken    = 1'b0;
        pat_go_taken    = 1'b0;
        memAddrA        = '0;
        memAddrB        = '0;
        memWeA          = 1'b0;
        memWdataA       = '0;
        cpuWrAck        = 1'b0;

        if (state_q == PAT_B1) begin
            memAddrA = row_byte(pat_addr_q, 2'd2);
            memAddrB = row_byte(pat_addr_q, 2'd3);
            pat_b1_d = 1'b1;
            state_d  = IDLE;
        end else if (sat_pend_q) begin
            memAddrA   = sat_pend_addr_q[0];
            memAddrB   = sat_pend_addr_q[1];
            sat_rd_d   = 1'b1;
            sat_pend_d = 1'b0;
        end else if (satGo) begin
            memAddrA     = satAddr[0];
            memAddrB     = satAddr[1];
            sat_rd_d     = 1'b1;
            sat_go_taken = 1'b1;
        end else if (pat_pend_q) begin
            memAddrA   = pat_pend_addr_q;
            memAddrB   = row_byte(pat_pend_addr_q, 2'd1);
            pat_addr_d = pat_pend_addr_q;
            pat_b0_d   = 1'b1;
            pat_pend_d = 1'b0;
            state_d    = PAT_B1;
        end else if (patGo) begin
            memAddrA     = pat_go_addr;
            memAddrB     = row_byte(pat_go_addr, 2'd1);
            pat_addr_d   = pat_go_addr;
            pat_b0_d     = 1'b1;
            pat_go_taken = 1'b1;
            state_d      = PAT_B1;
        end else if (cpuWrReq) begin
            memAddrA  = cpuAddr;
            memWeA    = 1'b1;
            memWdataA = cpuData;
            cpuWrAck  = 1'b1;
        end

        // A go that did not win the ports is parked; a newer one overwrites it.
        if (satGo && !sat_go_taken) begin
            sat_pend_d      = 1'b1;
            sat_pend_addr_d = satAddr;
            collision_d     = 1'b1;
        end
        if (patGo && !pat_go_taken) begin
            pat_pend_d      = 1'b1;
            pat_pend_addr_d = pat_go_addr;
            collision_d     = 1'b1;
        end
    end

    function automatic logic collision_q_int();
        return collision;
    endfunction

    // State, pending requests and read-beat tracking registers.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q         <= IDLE;
            sat_pend_q      <= 1'b0;
            sat_pend_addr_q <= '0;
            pat_pend_q      <= 1'b0;
            pat_pend_addr_q <= '0;
            pat_addr_q      <= '0;
            sat_rd_q        <= 1'b0;
            pat_b0_q        <= 1'b0;
            pat_b1_q        <= 1'b0;
            collision       <= 1'b0;
        end else begin
            state_q         <= state_d;
            sat_pend_q      <= sat_pend_d;
            sat_pend_addr_q <= sat_pend_addr_d;
            pat_pend_q      <= pat_pend_d;
            pat_pend_addr_q <= pat_pend_addr_d;
            pat_addr_q      <= pat_addr_d;
            sat_rd_q        <= sat_rd_d;
            pat_b0_q        <= pat_b0_d;
            pat_b1_q        <= pat_b1_d;
            collision       <= collision_d;
        end
    end

    // Capture returned RAM bytes one cycle after issue; lanes hold until overwritten.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            sprData  <= '0;
            satValid <= 1'b0;
            patValid <= 1'b0;
        end else begin
            if (sat_rd_q) begin
                sprData[4] <= memRdataA;
                sprData[5] <= memRdataB;
            end
            if (pat_b0_q) begin
                sprData[0] <= memRdataA;
                sprData[1] <= memRdataB;
            end
            if (pat_b1_q) begin
                sprData[2] <= memRdataA;
                sprData[3] <= memRdataB;
            end
            satValid <= sat_rd_q;
            patValid <= pat_b1_q;
        end
    end

endmodule

// File: tb/tb_vdp_vram_sprite_server.sv
// Bench for vdp_vram_sprite_server: behavioural dual-port VRAM plus a scoreboard
// of expected SAT / pattern results checked when the valid pulses appear.
module tb_vdp_vram_sprite_server;

    logic             clk;
    logic             rst_L;
    logic             satGo;
    logic [1:0][13:0] satAddr;
    logic             patGo;
    logic [7:0]       sprPat;
    logic [2:0]       patRow;
    logic             sprPatBase;
    logic             cpuWrReq;
    logic [13:0]      cpuAddr;
    logic [7:0]       cpuData;
    logic             cpuWrAck;
    logic [13:0]      memAddrA;
    logic [13:0]      memAddrB;
    logic             memWeA;
    logic [7:0]       memWdataA;
    logic [7:0]       memRdataA;
    logic [7:0]       memRdataB;
    logic [5:0][7:0]  sprData;
    logic             satValid;
    logic             patValid;
    logic             collision;

    typedef struct packed {
        logic [31:0] due;
        logic [31:0] data;
    } exp_t;

    exp_t        sat_q[$];
    exp_t        pat_q[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] cyc = 0;
    logic [7:0]  vram   [0:16383];
    logic [7:0]  shadow [0:16383];
    logic [13:0] lat_a, lat_b;
    logic        lat_we;
    logic [7:0]  lat_wd;

    vdp_vram_sprite_server #(
        .ADDR_W(14),
        .DATA_W(8)
    ) dut (
        .clk        (clk),
        .rst_L      (rst_L),
        .satGo      (satGo),
        .satAddr    (satAddr),
        .patGo      (patGo),
        .sprPat     (sprPat),
        .patRow     (patRow),
        .sprPatBase (sprPatBase),
        .cpuWrReq   (cpuWrReq),
        .cpuAddr    (cpuAddr),
        .cpuData    (cpuData),
        .cpuWrAck   (cpuWrAck),
        .memAddrA   (memAddrA),
        .memAddrB   (memAddrB),
        .memWeA     (memWeA),
        .memWdataA  (memWdataA),
        .memRdataA  (memRdataA),
        .memRdataB  (memRdataB),
        .sprData    (sprData),
        .satValid   (satValid),
        .patValid   (patValid),
        .collision  (collision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37) + (i >> 7));
    endfunction

    // VRAM model: ports sampled mid-cycle, written/read at the edge, one-cycle read latency.
    initial begin
        for (int i = 0; i < 16384; i++) vram[i] = init_byte(i);
        vram[14'h3F05] = 8'h40;
        vram[14'h3F06] = 8'hD0;
        memRdataA = '0;
        memRdataB = '0;
        forever begin
            @(negedge clk);
            lat_a  = memAddrA;
            lat_b  = memAddrB;
            lat_we = memWeA;
            lat_wd = memWdataA;
            @(posedge clk);
            memRdataA <= vram[lat_a];
            memRdataB <= vram[lat_b];
            if (lat_we) vram[lat_a] <= lat_wd;
        end
    end

    // Scoreboard: each valid pulse must match the oldest expectation, cycle and bytes.
    always @(negedge clk) begin
        if (rst_L) begin
            if (satValid) begin
                checks++;
                if (sat_q.size() == 0) begin
                    errors++;
                    $display("FAIL sat_unexpected: satValid at cycle %0d, none expected", cyc);
                end else begin
                    mon_e = sat_q.pop_front();
                    if (cyc !== mon_e.due || {sprData[5], sprData[4]} !== mon_e.data[15:0]) begin
                        errors++;
                        $display("FAIL sat_data: got cycle %0d bytes %h, want cycle %0d bytes %h",
                                 cyc, {sprData[5], sprData[4]}, mon_e.due, mon_e.data[15:0]);
                    end
                end
            end
            if (patValid) begin
                checks++;
                if (pat_q.size() == 0) begin
                    errors++;
                    $display("FAIL pat_unexpected: patValid at cycle %0d, none expected", cyc);
                end else begin
                    mon_e = pat_q.pop_front();
                    if (cyc !== mon_e.due ||
                        {sprData[3], sprData[2], sprData[1], sprData[0]} !== mon_e.data) begin
                        errors++;
                        $display("FAIL pat_data: got cycle %0d bytes %h, want cycle %0d bytes %h",
                                 cyc, {sprData[3], sprData[2], sprData[1], sprData[0]},
                                 mon_e.due, mon_e.data);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sat(input logic [31:0] due, input logic [13:0] a0, input logic [13:0] a1);
        exp_t e;
        e.due  = due;
        e.data = {16'h0, shadow[a1], shadow[a0]};
        sat_q.push_back(e);
    endtask

    task automatic push_pat(input logic [31:0] due, input logic [13:0] a);
        exp_t e;
        e.due  = due;
        e.data = {shadow[14'(a + 3)], shadow[14'(a + 2)], shadow[14'(a + 1)], shadow[a]};
        pat_q.push_back(e);
    endtask

    task automatic test_reset();
        rst_L = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({satValid, patValid, cpuWrAck, memWeA, collision} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000",
                     {satValid, patValid, cpuWrAck, memWeA, collision});
        end
        checks++;
        if (memAddrA !== 14'h0 || memAddrB !== 14'h0 || sprData !== 48'h0) begin
            errors++;
            $display("FAIL reset_data: got addrA %h addrB %h spr %h want all 0",
                     memAddrA, memAddrB, sprData);
        end
        rst_L = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if ({satValid, patValid, collision} !== 3'b0) begin
            errors++;
            $display("FAIL reset_release: got %b want 000", {satValid, patValid, collision});
        end
        tick();
    endtask

    task automatic test_sat_fetch();
        push_sat(cyc + 2, 14'h3F05, 14'h3F06);
        satAddr[0] = 14'h3F05;
        satAddr[1] = 14'h3F06;
        satGo      = 1'b1;
        @(negedge clk);
        checks++;
        if (memAddrA !== 14'h3F05 || memAddrB !== 14'h3F06) begin
            errors++;
            $display("FAIL sat_addr: got %h/%h want 3f05/3f06", memAddrA, memAddrB);
        end
        tick();
        satGo = 1'b0;
        repeat (3) tick();
        checks++;
        if (sprData[4] !== 8'h40 || sprData[5] !== 8'hD0) begin
            errors++;
            $display("FAIL sat_hold: got %h/%h want 40/d0", sprData[4], sprData[5]);
        end
    endtask

    task automatic test_pattern();
        logic [13:0] a;
        logic [13:0] want_a;
        for (int i = 0; i < 4; i++) begin
            sprPatBase = (i == 0) ? 1'b1 : i[0];
            sprPat     = (i == 0) ? 8'h03 : 8'(8'h51 * i);
            patRow     = (i == 0) ? 3'd5 : 3'(i * 3);
            a          = {sprPatBase, sprPat, patRow, 2'b00};
            want_a     = (i == 0) ? 14'h2074 : a;
            push_pat(cyc + 3, a);
            patGo = 1'b1;
            @(negedge clk);
            checks++;
            if (memAddrA !== want_a || memAddrB !== 14'(want_a + 1)) begin
                errors++;
                $display("FAIL pat_beat0[%0d]: got %h/%h want %h/%h",
                         i, memAddrA, memAddrB, want_a, 14'(want_a + 1));
            end
            tick();
            patGo = 1'b0;
            @(negedge clk);
            checks++;
            if (memAddrA !== 14'(want_a + 2) || memAddrB !== 14'(want_a + 3)) begin
                errors++;
                $display("FAIL pat_beat1[%0d]: got %h/%h want %h/%h",
                         i, memAddrA, memAddrB, 14'(want_a + 2), 14'(want_a + 3));
            end
            tick();
        end
        repeat (4) tick();
        checks++;
        if (collision !== 1'b0) begin
            errors++;
            $display("FAIL pat_no_collision: got %b want 0", collision);
        end
    endtask

    task automatic test_collision();
        logic [31:0] t;
        t          = cyc;
        satAddr[0] = 14'h0100;
        satAddr[1] = 14'h0101;
        satGo      = 1'b1;
        sprPatBase = 1'b0;
        sprPat     = 8'h10;
        patRow     = 3'd2;
        patGo      = 1'b1;
        push_sat(t + 2, 14'h0100, 14'h0101);
        push_pat(t + 4, 14'h0208);
        @(negedge clk);
        checks++;
        if (memAddrA !== 14'h0100 || memAddrB !== 14'h0101) begin
            errors++;
            $display("FAIL coll_sat_first: got %h/%h want 0100/0101", memAddrA, memAddrB);
        end
        tick();
        satGo  = 1'b0;
        patGo  = 1'b0;
        sprPat = 8'hFF;
        @(negedge clk);
        checks++;
        if (memAddrA !== 14'h0208 || memAddrB !== 14'h0209 || collision !== 1'b1) begin
            errors++;
            $display("FAIL coll_pat_late: got %h/%h coll %b want 0208/0209 coll 1",
                     memAddrA, memAddrB, collision);
        end
        tick();
        @(negedge clk);
        checks++;
        if (memAddrA !== 14'h020A || memAddrB !== 14'h020B) begin
            errors++;
            $display("FAIL coll_pat_beat1: got %h/%h want 020a/020b", memAddrA, memAddrB);
        end
        repeat (4) tick();

        t          = cyc;
        sprPatBase = 1'b1;
        sprPat     = 8'h22;
        patRow     = 3'd7;
        patGo      = 1'b1;
        push_pat(t + 3, 14'h245C);
        tick();
        patGo      = 1'b0;
        satAddr[0] = 14'h3F05;
        satAddr[1] = 14'h3F06;
        satGo      = 1'b1;
        push_sat(t + 4, 14'h3F05, 14'h3F06);
        @(negedge clk);
        checks++;
        if (memAddrA !== 14'h245E || memAddrB !== 14'h245F) begin
            errors++;
            $display("FAIL coll_b1_wins: got %h/%h want 245e/245f", memAddrA, memAddrB);
        end
        tick();
        satGo      = 1'b0;
        satAddr[0] = 14'h0;
        satAddr[1] = 14'h0;
        @(negedge clk);
        checks++;
        if (memAddrA !== 14'h3F05 || memAddrB !== 14'h3F06) begin
            errors++;
            $display("FAIL coll_sat_deferred: got %h/%h want 3f05/3f06", memAddrA, memAddrB);
        end
        repeat (6) tick();
        checks++;
        if (collision !== 1'b1) begin
            errors++;
            $display("FAIL coll_sticky: got %b want 1", collision);
        end
    endtask

    task automatic test_cpu_write();
        logic [13:0] a;
        cpuAddr  = 14'h1234;
        cpuData  = 8'hA5;
        cpuWrReq = 1'b1;
        for (int j = 0; j < 2; j++) begin
            sprPatBase = 1'b0;
            sprPat     = 8'(8'h30 + j);
            patRow     = 3'(j);
            a          = {sprPatBase, sprPat, patRow, 2'b00};
            push_pat(cyc + 3, a);
            patGo = 1'b1;
            @(negedge clk);
            checks++;
            if (cpuWrAck !== 1'b0 || memWeA !== 1'b0) begin
                errors++;
                $display("FAIL cpu_blocked_b0[%0d]: got ack %b we %b want 0 0", j, cpuWrAck, memWeA);
            end
            tick();
            patGo = 1'b0;
            @(negedge clk);
            checks++;
            if (cpuWrAck !== 1'b0 || memWeA !== 1'b0) begin
                errors++;
                $display("FAIL cpu_blocked_b1[%0d]: got ack %b we %b want 0 0", j, cpuWrAck, memWeA);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (cpuWrAck !== 1'b1 || memWeA !== 1'b1 || memAddrA !== 14'h1234 ||
            memWdataA !== 8'hA5) begin
            errors++;
            $display("FAIL cpu_write: got ack %b we %b addr %h data %h want 1 1 1234 a5",
                     cpuWrAck, memWeA, memAddrA, memWdataA);
        end
        tick();
        cpuWrReq = 1'b0;
        shadow[14'h1234] = 8'hA5;
        @(negedge clk);
        checks++;
        if (cpuWrAck !== 1'b0 || memWeA !== 1'b0) begin
            errors++;
            $display("FAIL cpu_ack_once: got ack %b we %b want 0 0", cpuWrAck, memWeA);
        end
        tick();
        satAddr[0] = 14'h1234;
        satAddr[1] = 14'h1235;
        satGo      = 1'b1;
        push_sat(cyc + 2, 14'h1234, 14'h1235);
        tick();
        satGo = 1'b0;
        repeat (4) tick();
        checks++;
        if (sprData[4] !== 8'hA5) begin
            errors++;
            $display("FAIL cpu_readback: got %h want a5", sprData[4]);
        end
    endtask

    task automatic test_reset_mid_fetch();
        sprPatBase = 1'b1;
        sprPat     = 8'h44;
        patRow     = 3'd1;
        patGo      = 1'b1;
        tick();
        patGo = 1'b0;
        #2;
        rst_L = 1'b0;
        #1;
        checks++;
        if ({satValid, patValid, cpuWrAck, memWeA, collision} !== 5'b0 ||
            memAddrA !== 14'h0 || memAddrB !== 14'h0 || sprData !== 48'h0) begin
            errors++;
            $display("FAIL reset_mid_fetch: got flags %b addr %h/%h spr %h want all 0",
                     {satValid, patValid, cpuWrAck, memWeA, collision},
                     memAddrA, memAddrB, sprData);
        end
        @(posedge clk);
        #2;
        rst_L = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (patValid !== 1'b0 || satValid !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_valid[%0d]: got pat %b sat %b want 0 0",
                         i, patValid, satValid);
            end
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) shadow[i] = init_byte(i);
        shadow[14'h3F05] = 8'h40;
        shadow[14'h3F06] = 8'hD0;
        rst_L      = 1'b0;
        satGo      = 1'b0;
        satAddr    = '0;
        patGo      = 1'b0;
        sprPat     = '0;
        patRow     = '0;
        sprPatBase = 1'b0;
        cpuWrReq   = 1'b0;
        cpuAddr    = '0;
        cpuData    = '0;

        test_reset();
        test_sat_fetch();
        test_pattern();
        test_collision();
        test_cpu_write();
        test_reset_mid_fetch();

        checks++;
        if (sat_q.size() != 0 || pat_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d sat / %0d pat outstanding want 0 / 0",
                     sat_q.size(), pat_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vdp_vram_sprite_server.md
# vdp_vram_sprite_server

Services the VRAM read requests issued by the VDP sprite engine and drives the data it consumes. Two request types share the VRAM read ports: sprite-attribute-table (SAT) byte-pair fetches and 4-byte sprite pattern-row fetches. Each request is turned into accesses on the dual-port VRAM, and the returned bytes are registered into the shared sprite data bus. CPU VRAM writes use port A in free cycles. The block sits between the sprite interface and the VRAM BRAM.

## Interface
Parameters:
- ADDR_W, 14, VRAM byte address width.
- DATA_W, 8, VRAM byte width.

Ports:
- clk  in  1  system clock
- rst_L  in  1  reset, asynchronous, active-low
- satGo  in  1  SAT fetch request, one-cycle pulse
- satAddr  in  2x14  SAT byte addresses, slot 0 and slot 1, valid with satGo
- patGo  in  1  pattern-row fetch request, one-cycle pulse
- sprPat  in  8  sprite pattern index, valid with patGo
- patRow  in  3  pattern row 0..7, valid with patGo
- sprPatBase  in  1  sprite pattern table select (regFile[6] bit 2): 0 selects 0x0000, 1 selects 0x2000
- cpuWrReq  in  1  CPU write request, held until ack
- cpuAddr  in  14  CPU write address
- cpuData  in  8  CPU write data
- cpuWrAck  out  1  one-cycle pulse in the cycle the write is issued to port A
- memAddrA, memAddrB  out  14 each  VRAM port addresses (combinational)
- memWeA  out  1  port A write enable
- memWdataA  out  8  port A write data
- memRdataA, memRdataB  in  8 each  VRAM read data, one-cycle latency
- sprData  out  6x8  data bus: [4],[5] carry SAT bytes; [0]..[3] carry pattern bytes
- satValid, patValid  out  1 each  one-cycle pulse when the fetched data is visible
- collision  out  1  sticky flag for overlapping requests

## Operation
- States: IDLE, PAT_B1.
- Pattern address is {sprPatBase, sprPat, patRow, 2'b00}. Beat 0 reads +0 and +1; beat 1 reads +2 and +3.
- IDLE with satGo: memAddrA = satAddr[0], memAddrB = satAddr[1]. On the next cycle memRdataA is captured into sprData[4] and memRdataB into sprData[5]. satValid then pulses.
- IDLE with patGo (no satGo): beat 0 addresses go to ports A/B, and the state moves to PAT_B1.
- PAT_B1: beat 1 addresses go to ports A/B. Beat 0 data is captured into sprData[0]/[1], then beat 1 data into sprData[2]/[3]. patValid pulses once all four bytes are visible. The state returns to IDLE.
- Priority in each cycle, highest first: in-flight PAT_B1 beat, pending SAT, new satGo, pending pat, new patGo, CPU write.
- A CPU write is issued on port A only in an IDLE cycle with no read issued: memWeA=1, cpuWrAck=1. Port B is unused in that cycle.
- Deferred request: a go that cannot issue (satGo in PAT_B1, or patGo in the same cycle as satGo) is held in a one-deep pending register for its type. The pending register latches its address/pattern inputs at go time. Any deferral sets collision.
- A go arriving while the same type is already pending overwrites the pending request and sets collision.
- collision is cleared only by reset.
- sprData registers hold their value until overwritten; there is no clear on the idle path.
- Reset: state IDLE, pending registers empty, sprData all 0, satValid=patValid=cpuWrAck=memWeA=collision=0, memAddrA/B=0.

## Timing
- satGo sampled in cycle t: addresses drive ports in t; RAM data returns in t+1; sprData[4]/[5] are registered and satValid=1 in t+2. The sprite FSM loads two cycles after go.
- patGo in t: beat 0 in t, beat 1 in t+1; sprData[0]/[1] valid at t+2, sprData[2]/[3] valid at t+3; patValid=1 in t+3.
- Back-to-back patGo every 2 cycles is sustained with no deferral.
- A deferred request issues in the first free cycle. Its latency is measured from issue.
- Worst-case CPU write wait is 2 cycles after reads stop.
- Reset asserted mid-fetch aborts the fetch; no valid pulse follows reset release.

## Test plan
- Reset: assert rst_L=0 mid-PAT_B1 -> all outputs 0, state IDLE, no patValid after release.
- SAT fetch: VRAM[0x3F05]=0x40, VRAM[0x3F06]=0xD0; satGo with addrs 0x3F05/0x3F06 at t -> sprData[4]=0x40, sprData[5]=0xD0, satValid=1 exactly at t+2.
- Pattern fetch: sprPatBase=1, sprPat=0x03, patRow=5 -> port addresses 0x2074/0x2075 at t, 0x2076/0x2077 at t+1; patValid at t+3 with bytes in order; repeat every 2 cycles with no collision.
- Collision: satGo and patGo same cycle -> SAT issued at t, pat issued at t+1, collision=1 sticky; satGo during PAT_B1 -> SAT issued one cycle late.
- CPU write: cpuWrReq held during a pattern stream -> ack only in a free IDLE cycle, memWeA=1 with correct addr/data, then readback via satGo returns the written byte.
